// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage (PC, imem req/ack handshake, branch/jump redirect, imem timeout).
// Optional FETCH_PERF_CNT_EN macro adds fetch/stall performance counter outputs.
module fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        run_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o32,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i32,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o32,
   output logic [5:0]  op_o6,
   output logic [31:0] pc_o32,
   output logic [31:0] pc_plus4_o32,
   input  logic        branch_taken_i,
   input  logic [15:0] branch_imm_i16,
   input  logic        jump_i,
   input  logic [25:0] jump_addr_i26,
   output logic        fetch_err_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o32,
   output logic [31:0] stall_cnt_o32
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_VALID,
      S_ERR
   } state_t;

   localparam logic [7:0]  TIMEOUT_LAST     = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] instr_reg, instr_next;
   logic [7:0]  tmo_cnt_reg, tmo_cnt_next;

   logic [31:0] pc_plus4;
   logic [31:0] branch_off;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] redirect_pc;
   logic        consume;

   assign pc_plus4      = pc_reg + 32'd4;
   assign branch_off    = {{14{branch_imm_i16[15]}}, branch_imm_i16, 2'b00};
   assign branch_target = pc_plus4 + branch_off;
   assign jump_target   = {pc_plus4[31:28], jump_addr_i26, 2'b00};
   assign consume       = (state_reg == S_VALID) && instr_ready_i;

   // Jump outranks branch when the executing stage raises both.
   always_comb begin
      redirect_pc = pc_plus4;
      if (jump_i) begin
         redirect_pc = jump_target;
      end else if (branch_taken_i) begin
         redirect_pc = branch_target;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= S_IDLE;
         pc_reg      <= RESET_PC_ALIGNED;
         instr_reg   <= 32'd0;
         tmo_cnt_reg <= 8'd0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         instr_reg   <= instr_next;
         tmo_cnt_reg <= tmo_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      instr_next   = instr_reg;
      tmo_cnt_next = tmo_cnt_reg;
      case (state_reg)
         S_IDLE: begin
            tmo_cnt_next = 8'd0;
            if (run_i) begin
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            // An ack in the final allowed cycle still completes the fetch.
            if (imem_ack_i) begin
               instr_next   = imem_rdata_i32;
               tmo_cnt_next = 8'd0;
               state_next   = S_VALID;
            end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
               tmo_cnt_next = 8'd0;
               state_next   = S_ERR;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 8'd1;
            end
         end
         S_VALID: begin
            if (instr_ready_i) begin
               pc_next    = redirect_pc;
               state_next = run_i ? S_REQ : S_IDLE;
            end
         end
         S_ERR: begin
            state_next = S_ERR;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign imem_req_o    = (state_reg == S_REQ);
   assign imem_addr_o32 = pc_reg;
   assign instr_valid_o = (state_reg == S_VALID);
   assign instr_o32     = instr_reg;
   assign op_o6         = instr_reg[31:26];
   assign pc_o32        = pc_reg;
   assign pc_plus4_o32  = pc_plus4;
   assign fetch_err_o   = (state_reg == S_ERR);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] stall_cnt_reg;
   logic        stall;

   assign stall = ((state_reg == S_VALID) && !instr_ready_i) ||
                  ((state_reg == S_REQ) && !imem_ack_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_cnt_reg <= 32'd0;
         stall_cnt_reg <= 32'd0;
      end else begin
         if (consume) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         end
         if (stall) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
      end
   end

   assign fetch_cnt_o32 = fetch_cnt_reg;
   assign stall_cnt_o32 = stall_cnt_reg;
`else
   logic unused_consume;
   assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetch/redirect vectors with a scoreboard,
// plus sequences for timeout, ack-at-limit, reset mid-request and PC wrap.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam logic [31:0] MAIN_PC = 32'h0040_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
   localparam int          TMO     = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        run, ack, ready, br, jmp;
   logic [31:0] rdata;
   logic [15:0] imm;
   logic [25:0] jaddr;
   logic        req, valid, err;
   logic [31:0] addr, instr, pc, pc4;
   logic [5:0]  op;

   logic        w_run, w_ack, w_ready, w_br, w_jmp;
   logic [31:0] w_rdata;
   logic [15:0] w_imm;
   logic [25:0] w_jaddr;
   logic        w_req, w_valid, w_err;
   logic [31:0] w_addr, w_instr, w_pc, w_pc4;
   logic [5:0]  w_op;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

   fetch_unit #(.RESET_PC(MAIN_PC), .TIMEOUT_CYCLES(TMO)) u_dut (
      .clk_i(clk), .rst_i(rst), .run_i(run),
      .imem_req_o(req), .imem_addr_o32(addr), .imem_ack_i(ack), .imem_rdata_i32(rdata),
      .instr_valid_o(valid), .instr_ready_i(ready), .instr_o32(instr), .op_o6(op),
      .pc_o32(pc), .pc_plus4_o32(pc4),
      .branch_taken_i(br), .branch_imm_i16(imm), .jump_i(jmp), .jump_addr_i26(jaddr),
      .fetch_err_o(err)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt_o32(fetch_cnt), .stall_cnt_o32(stall_cnt)
`endif
   );

   fetch_unit #(.RESET_PC(WRAP_PC), .TIMEOUT_CYCLES(TMO)) u_wrap (
      .clk_i(clk), .rst_i(rst), .run_i(w_run),
      .imem_req_o(w_req), .imem_addr_o32(w_addr), .imem_ack_i(w_ack), .imem_rdata_i32(w_rdata),
      .instr_valid_o(w_valid), .instr_ready_i(w_ready), .instr_o32(w_instr), .op_o6(w_op),
      .pc_o32(w_pc), .pc_plus4_o32(w_pc4),
      .branch_taken_i(w_br), .branch_imm_i16(w_imm), .jump_i(w_jmp), .jump_addr_i26(w_jaddr),
      .fetch_err_o(w_err)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt_o32(w_fetch_cnt), .stall_cnt_o32(w_stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] exp_addr;
      logic [31:0] rdata;
      logic        br;
      logic [15:0] imm;
      logic        jmp;
      logic [25:0] jaddr;
      int          stall;
      logic        run_after;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   vec_t vecs[6];
   sb_t  sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   model_fetch = 0;
   int   model_stall = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_req(input bit use_wrap);
      int n = 0;
      while (((use_wrap ? w_req : req) !== 1'b1) && n < 40) begin
         step();
         n++;
      end
      chk("req_seen", {31'd0, (use_wrap ? w_req : req)}, 32'd1);
   endtask

   task automatic check_presented(input string tag);
      sb_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_instr"}, instr, e.instr);
         chk({tag, "_op"}, {26'd0, op}, {26'd0, e.instr[31:26]});
         chk({tag, "_pc"}, pc, e.pc);
         chk({tag, "_pc4"}, pc4, e.pc + 32'd4);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      bit          req_held;

      vecs[0] = '{32'h0040_0000, 32'h2008_0005, 1'b0, 16'h0000, 1'b0, 26'h0, 0, 1'b1};
      vecs[1] = '{32'h0040_0004, 32'h8C09_0000, 1'b0, 16'h0000, 1'b0, 26'h0, 3, 1'b1};
      vecs[2] = '{32'h0040_0008, 32'h1000_FFFE, 1'b1, 16'hFFFE, 1'b0, 26'h0, 0, 1'b1};
      vecs[3] = '{32'h0040_0004, 32'h0810_0000, 1'b1, 16'h0005, 1'b1, 26'h010_0000, 0, 1'b1};
      vecs[4] = '{32'h0040_0000, 32'hAC0A_0004, 1'b1, 16'h7FFF, 1'b0, 26'h0, 0, 1'b1};
      vecs[5] = '{32'h0042_0000, 32'h0000_0020, 1'b0, 16'h0000, 1'b0, 26'h0, 0, 1'b0};

      rst = 1'b1; run = 1'b0; ack = 1'b0; ready = 1'b0; br = 1'b0; jmp = 1'b0;
      rdata = '0; imm = '0; jaddr = '0;
      w_run = 1'b0; w_ack = 1'b0; w_ready = 1'b0; w_br = 1'b0; w_jmp = 1'b0;
      w_rdata = '0; w_imm = '0; w_jaddr = '0;

      #12;
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", pc, MAIN_PC);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run = 1'b1;

      for (int i = 0; i < 6; i++) begin
         wait_req(1'b0);
         chk("fetch_addr", addr, vecs[i].exp_addr);
         chk("fetch_valid_low", {31'd0, valid}, 32'd0);
         ack = 1'b1;
         rdata = vecs[i].rdata;
         sb_q.push_back('{vecs[i].exp_addr, vecs[i].rdata});
         step();
         ack = 1'b0;
         rdata = '0;
         $display("fetch[%0d] addr=%h instr=%h op=%h", i, addr, instr, op);
         chk("fetch_valid", {31'd0, valid}, 32'd1);
         check_presented("vec");
         held = instr;
         for (int s = 0; s < vecs[i].stall; s++) begin
            ack = 1'b1;
            rdata = 32'hDEAD_BEEF;
            step();
            model_stall++;
            chk("stall_instr", instr, held);
            chk("stall_req", {31'd0, req}, 32'd0);
            chk("stall_valid", {31'd0, valid}, 32'd1);
         end
         ack = 1'b0;
         rdata = '0;
         ready = 1'b1;
         br = vecs[i].br;
         imm = vecs[i].imm;
         jmp = vecs[i].jmp;
         jaddr = vecs[i].jaddr;
         run = vecs[i].run_after;
         model_fetch++;
         step();
         ready = 1'b0; br = 1'b0; jmp = 1'b0; imm = '0; jaddr = '0;
      end

      step();
      chk("park_req", {31'd0, req}, 32'd0);
      chk("park_valid", {31'd0, valid}, 32'd0);
      chk("park_pc", pc, 32'h0042_0004);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", fetch_cnt, 32'(model_fetch));
      chk("perf_stall", stall_cnt, 32'(model_stall));
`endif

      // Timeout: sixteen REQ cycles without ack.
      run = 1'b1;
      wait_req(1'b0);
      chk("tmo_addr", addr, 32'h0042_0004);
      req_held = 1'b1;
      for (int k = 2; k <= TMO; k++) begin
         step();
         if (req !== 1'b1 || err !== 1'b0) req_held = 1'b0;
      end
      chk("tmo_req_held", {31'd0, req_held}, 32'd1);
      step();
      $display("timeout err=%0b req=%0b", err, req);
      chk("tmo_err", {31'd0, err}, 32'd1);
      chk("tmo_req_off", {31'd0, req}, 32'd0);
      ack = 1'b1;
      rdata = 32'h1234_5678;
      step();
      ack = 1'b0;
      step();
      chk("err_sticky", {31'd0, err}, 32'd1);
      chk("err_valid", {31'd0, valid}, 32'd0);
      chk("err_no_capture", instr, 32'h0000_0020);

      // Ack in the sixteenth REQ cycle wins over the timeout.
      rst = 1'b1;
      #2;
      chk("rst_clears_err", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_req(1'b0);
      chk("limit_addr", addr, MAIN_PC);
      for (int k = 2; k <= TMO; k++) step();
      ack = 1'b1;
      rdata = 32'h3C01_1234;
      sb_q.push_back('{MAIN_PC, 32'h3C01_1234});
      step();
      ack = 1'b0;
      $display("limit_ack valid=%0b err=%0b instr=%h", valid, err, instr);
      chk("limit_valid", {31'd0, valid}, 32'd1);
      chk("limit_err", {31'd0, err}, 32'd0);
      check_presented("limit");

      // Reset while a request is outstanding; the late ack must be ignored.
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("mid_req", {31'd0, req}, 32'd1);
      chk("mid_addr", addr, 32'h0040_0004);
      #2;
      rst = 1'b1;
      #1;
      chk("async_req", {31'd0, req}, 32'd0);
      chk("async_pc", pc, MAIN_PC);
      chk("async_instr", instr, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ack = 1'b1;
      rdata = 32'hFFFF_FFFF;
      step();
      ack = 1'b0;
      chk("late_ack_valid", {31'd0, valid}, 32'd0);
      chk("late_ack_instr", instr, 32'd0);
      chk("restart_req", {31'd0, req}, 32'd1);
      chk("restart_addr", addr, MAIN_PC);
      ack = 1'b1;
      rdata = 32'h2408_0001;
      sb_q.push_back('{MAIN_PC, 32'h2408_0001});
      step();
      ack = 1'b0;
      $display("restart addr=%h instr=%h", pc, instr);
      chk("restart_valid", {31'd0, valid}, 32'd1);
      check_presented("restart");

      // PC wrap on the second instance.
      w_run = 1'b1;
      wait_req(1'b1);
      chk("wrap_addr", w_addr, WRAP_PC);
      chk("wrap_pc4", w_pc4, 32'd0);
      w_ack = 1'b1;
      w_rdata = 32'h0000_000C;
      step();
      w_ack = 1'b0;
      chk("wrap_valid", {31'd0, w_valid}, 32'd1);
      chk("wrap_instr", w_instr, 32'h0000_000C);
      chk("wrap_op", {26'd0, w_op}, 32'd0);
      w_ready = 1'b1;
      step();
      w_ready = 1'b0;
      $display("wrap next addr=%h", w_addr);
      chk("wrap_next_req", {31'd0, w_req}, 32'd1);
      chk("wrap_next_addr", w_addr, 32'd0);
      chk("wrap_next_pc", w_pc, 32'd0);
      chk("wrap_err", {31'd0, w_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("wrap_perf_fetch", w_fetch_cnt, 32'd1);
      chk("wrap_perf_stall", w_stall_cnt, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the MIPS core; sits directly upstream of the main decoder and supplies the opcode field it decodes. Holds the PC, issues req/ack reads to instruction memory, presents one instruction at a time to the decode/execute stage, and computes the next PC from that stage's branch/jump redirect. Detects memory that never responds via a timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (must be word aligned)
TIMEOUT_CYCLES, 16, max cycles in REQ without ack before error (1..255)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
run_i  in  1  fetch enable; 0 parks the unit in IDLE after the current instruction is consumed
imem_req_o  out  1  read request to instruction memory
imem_addr_o32  out  32  byte address of request (= PC)
imem_ack_i  in  1  read data valid, single-cycle pulse
imem_rdata_i32  in  32  instruction word, valid with ack
instr_valid_o  out  1  instr_o32 holds a valid instruction
instr_ready_i  in  1  downstream consumes the instruction this cycle
instr_o32  out  32  registered instruction word
op_o6  out  6  instr_o32[31:26], feeds decoder opcode input
pc_o32  out  32  PC of the instruction being fetched/presented
pc_plus4_o32  out  32  pc_o32 + 4 (link value for JAL)
branch_taken_i  in  1  redirect to branch target, sampled on consume
branch_imm_i16  in  16  branch offset, word units, signed
jump_i  in  1  redirect to jump target, sampled on consume
jump_addr_i26  in  26  jump index field
fetch_err_o  out  1  sticky imem timeout flag

Behaviour:
- Reset (async, any state, mid-request included): state=IDLE, pc=RESET_PC, instr_o32=0, imem_req_o=0, instr_valid_o=0, fetch_err_o=0, timeout counter=0. An ack arriving after reset deasserts is ignored.
- States IDLE, REQ, VALID, ERR; outputs are decoded from registered state only (no combinational in-to-out paths except op_o6/pc_plus4_o32 from registers).
- IDLE: req=0, valid=0. run_i=1 -> REQ next cycle.
- REQ: imem_req_o=1, imem_addr_o32=pc stable until ack. Counter increments each REQ cycle without ack. imem_ack_i=1 -> instr_o32<=imem_rdata_i32, counter<=0, -> VALID. Counter reaching TIMEOUT_CYCLES with no ack -> ERR. Ack on the same cycle the limit is reached: ack wins.
- Minimum latency: request issued cycle N, ack at N -> instr_valid_o at N+1.
- VALID: instr_valid_o=1, instr_o32 and pc_o32 stable until consumed. On instr_ready_i=1: pc<=next_pc; -> REQ if run_i else IDLE. instr_ready_i ignored outside VALID.
- next_pc priority: jump_i > branch_taken_i > sequential.
  sequential: pc+4, wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  branch: pc+4 + (sign_extend(branch_imm_i16) << 2), modulo 2^32.
  jump: {pc_plus4[31:28], jump_addr_i26, 2'b00}.
- imem_ack_i outside REQ is ignored (no state change, no data capture).
- ERR: req=0, valid=0, fetch_err_o=1; leaves only via reset.
- PC bits [1:0] always 0.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs fetch_cnt_o32 (increments on every VALID consume) and stall_cnt_o32 (increments each cycle in VALID with instr_ready_i=0, or in REQ without ack); both reset to 0 and wrap at 2^32. When undefined, the ports and counters do not exist; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, run_i=1, ack next cycle with 32'h2008_0005 -> req with addr 32'h0040_0000, then valid=1, op_o6=6'h08, pc_plus4_o32=32'h0040_0004.
- Sequential consume x3, ack zero-wait -> addresses 0x00400000, 0x00400004, 0x00400008; ready held 0 for 3 cycles -> instr_o32 stable, no new req.
- Consume with branch_taken_i=1, branch_imm_i16=16'hFFFE at pc 0x00400008 -> next addr 0x00400004; jump_i=1 and branch_taken_i=1 together, jump_addr_i26=26'h0100000 -> next addr 0x00400000 (jump wins).
- No ack for TIMEOUT_CYCLES=16 cycles -> fetch_err_o=1, req=0 thereafter; ack on the 16th cycle instead -> VALID, no error.
- Assert rst_i mid-REQ, then ack after release -> ack ignored, unit restarts from RESET_PC; PC 32'hFFFF_FFFC sequential consume -> next addr 32'h0000_0000.
- With FETCH_PERF_CNT_EN: 5 consumes, 2 stall cycles -> fetch_cnt_o32=5, stall_cnt_o32=2.
